// File: rtl/imem_prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// master = stream source / memory side, slave = loader.
interface imem_prog_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_prog_loader.sv
// Loads a framed byte stream (16-bit word count, then 32-bit words MSB first)
// into instruction memory, holding the core in reset until the load completes.
module imem_prog_loader #(
  parameter int ADDR_W     = 10,
  parameter int IMEM_DEPTH = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_req,
  imem_prog_loader_if.slave   bus,
  output logic                cpu_rst_n,
  output logic                load_done,
  output logic                load_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR0  = 3'd1;
  localparam logic [2:0] S_HDR1  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_RUN   = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;

  localparam logic [16:0] DEPTH = 17'(IMEM_DEPTH);

  logic [2:0]        state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [31:0]       word_q, word_d;
  logic              cpu_rst_n_q, load_done_q, load_err_q;

  logic              byte_ready;
  logic              accept;
  logic [15:0]       hdr_count;

  assign byte_ready = (state_q == S_HDR0) || (state_q == S_HDR1) || (state_q == S_DATA);
  assign accept     = bus.byte_valid && byte_ready;
  assign hdr_count  = {count_q[15:8], bus.byte_in};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    index_d = index_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    case (state_q)
      S_IDLE: if (load_req) state_d = S_HDR0;
      S_HDR0: begin
        if (accept) begin
          count_d = {bus.byte_in, count_q[7:0]};
          state_d = S_HDR1;
        end
      end
      S_HDR1: begin
        if (accept) begin
          count_d = hdr_count;
          if (hdr_count == 16'd0) begin
            state_d = S_RUN;
          end else if ({1'b0, hdr_count} > DEPTH) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
            index_d = '0;
            bcnt_d  = '0;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          word_d = {word_q[23:0], bus.byte_in};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // Count check on the header guarantees index stays below IMEM_DEPTH.
        if (16'(index_q) == count_q - 16'd1) begin
          state_d = S_RUN;
        end else begin
          index_d = index_q + ADDR_W'(1);
          state_d = S_DATA;
        end
      end
      S_RUN, S_ERR: if (load_req) state_d = S_HDR0;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      index_q     <= '0;
      bcnt_q      <= '0;
      word_q      <= '0;
      cpu_rst_n_q <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      index_q     <= index_d;
      bcnt_q      <= bcnt_d;
      word_q      <= word_d;
      // Core is released one cycle after RUN is entered and held again as soon as RUN is left.
      cpu_rst_n_q <= (state_q == S_RUN) && (state_d == S_RUN);
      load_done_q <= (state_q == S_RUN) && (state_d == S_RUN);
      load_err_q  <= (state_d == S_ERR);
    end
  end

  assign bus.byte_ready = byte_ready;
  assign bus.imem_we    = (state_q == S_WRITE);
  assign bus.imem_addr  = index_q;
  assign bus.imem_wdata = word_q;
  assign cpu_rst_n      = cpu_rst_n_q;
  assign load_done      = load_done_q;
  assign load_err       = load_err_q;

endmodule

// File: tb/tb_imem_prog_loader.sv
// Scoreboarded bench for imem_prog_loader: expected memory writes are queued as
// streams are driven and matched against imem_we pulses.
module tb_imem_prog_loader;

  typedef struct packed {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  logic load_req;
  logic cpu_rst_n, load_done, load_err;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int wr_cnt    = 0;

  wr_t        exp_q[$];
  logic [7:0] bq[$];

  imem_prog_loader_if #(.ADDR_W(10)) bus ();

  imem_prog_loader #(.ADDR_W(10), .IMEM_DEPTH(1024)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_req  (load_req),
    .bus       (bus.slave),
    .cpu_rst_n (cpu_rst_n),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst === 1'b1 && bus.imem_we === 1'b1) begin
      wr_t e;
      wr_cnt++;
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write addr=%0h data=%08h expected none", bus.imem_addr, bus.imem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (bus.imem_addr !== e.a || bus.imem_wdata !== e.d)
          $display("FAIL write got addr=%0h data=%08h expected addr=%0h data=%08h",
                   bus.imem_addr, bus.imem_wdata, e.a, e.d);
        else
          pass_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ok);
    int unsigned n = 0;
    ok = 1'b0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    while (bus.byte_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (bus.byte_ready === 1'b1) begin
      tick();
      ok = 1'b1;
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_bq(input bit gaps, input int req_at);
    bit ok;
    for (int i = 0; i < bq.size(); i++) begin
      send_byte(bq[i], ok);
      if (!ok) begin
        total_cnt++;
        $display("FAIL byte_accept_timeout byte_index=%0d byte_ready=%b expected 1", i, bus.byte_ready);
      end
      if (gaps) begin
        if (i == req_at) load_req = 1'b1;
        tick();
        load_req = 1'b0;
      end
    end
    bq.delete();
  endtask

  task automatic push_word(input logic [9:0] a, input logic [31:0] d);
    exp_q.push_back('{a: a, d: d});
    for (int k = 3; k >= 0; k--) bq.push_back(d[k*8 +: 8]);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    load_req = 1'b0;
    bus.byte_in = '0;
    bus.byte_valid = 1'b0;
    repeat (2) tick();
    total_cnt++; if (bus.byte_ready !== 1'b0) $display("FAIL reset_byte_ready got %b expected 0", bus.byte_ready); else pass_cnt++;
    total_cnt++; if (bus.imem_we !== 1'b0) $display("FAIL reset_imem_we got %b expected 0", bus.imem_we); else pass_cnt++;
    total_cnt++; if (bus.imem_addr !== 10'd0) $display("FAIL reset_imem_addr got %0h expected 0", bus.imem_addr); else pass_cnt++;
    total_cnt++; if (bus.imem_wdata !== 32'd0) $display("FAIL reset_imem_wdata got %08h expected 0", bus.imem_wdata); else pass_cnt++;
    total_cnt++; if (cpu_rst_n !== 1'b0) $display("FAIL reset_cpu_rst_n got %b expected 0", cpu_rst_n); else pass_cnt++;
    total_cnt++; if (load_done !== 1'b0) $display("FAIL reset_load_done got %b expected 0", load_done); else pass_cnt++;
    total_cnt++; if (load_err !== 1'b0) $display("FAIL reset_load_err got %b expected 0", load_err); else pass_cnt++;
    rst = 1'b1;
    tick();
    total_cnt++; if (bus.byte_ready !== 1'b0) $display("FAIL idle_byte_ready got %b expected 0", bus.byte_ready); else pass_cnt++;
  endtask

  task automatic test_two_words();
    bit ok;
    int w0 = wr_cnt;
    pulse_req();
    total_cnt++; if (bus.byte_ready !== 1'b1) $display("FAIL hdr0_byte_ready got %b expected 1", bus.byte_ready); else pass_cnt++;
    bq.push_back(8'h00); bq.push_back(8'h02);
    push_word(10'd0, 32'h12345678);
    push_word(10'd1, 32'h9ABCDEF0);
    for (int i = 0; i < 10; i++) begin
      send_byte(bq[i], ok);
      if (!ok) begin
        total_cnt++;
        $display("FAIL two_words_timeout byte_index=%0d byte_ready=%b expected 1", i, bus.byte_ready);
      end
    end
    bq.delete();
    total_cnt++; if (bus.imem_we !== 1'b1) $display("FAIL we_after_last_byte got %b expected 1", bus.imem_we); else pass_cnt++;
    total_cnt++; if (bus.byte_ready !== 1'b0) $display("FAIL write_byte_ready got %b expected 0", bus.byte_ready); else pass_cnt++;
    tick();
    total_cnt++; if (cpu_rst_n !== 1'b0) $display("FAIL cpu_rst_n_one_cycle got %b expected 0", cpu_rst_n); else pass_cnt++;
    tick();
    total_cnt++; if (cpu_rst_n !== 1'b1) $display("FAIL cpu_rst_n_two_cycles got %b expected 1", cpu_rst_n); else pass_cnt++;
    total_cnt++; if (load_done !== 1'b1) $display("FAIL load_done_two_cycles got %b expected 1", load_done); else pass_cnt++;
    repeat (4) tick();
    total_cnt++; if (wr_cnt - w0 !== 2) $display("FAIL two_words_write_count got %0d expected 2", wr_cnt - w0); else pass_cnt++;
    total_cnt++; if (exp_q.size() !== 0) $display("FAIL two_words_pending got %0d expected 0", exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_zero_count();
    int w0 = wr_cnt;
    int n = 0;
    pulse_req();
    total_cnt++; if (cpu_rst_n !== 1'b0) $display("FAIL reload_cpu_rst_n got %b expected 0", cpu_rst_n); else pass_cnt++;
    total_cnt++; if (load_done !== 1'b0) $display("FAIL reload_load_done got %b expected 0", load_done); else pass_cnt++;
    bq.push_back(8'h00); bq.push_back(8'h00);
    send_bq(1'b0, -1);
    while (cpu_rst_n !== 1'b1 && n < 2) begin
      tick();
      n++;
    end
    total_cnt++; if (cpu_rst_n !== 1'b1) $display("FAIL zero_count_release got %b expected 1", cpu_rst_n); else pass_cnt++;
    repeat (3) tick();
    total_cnt++; if (wr_cnt !== w0) $display("FAIL zero_count_writes got %0d expected %0d", wr_cnt, w0); else pass_cnt++;
  endtask

  task automatic test_overflow();
    pulse_req();
    bq.push_back(8'h04); bq.push_back(8'h01);
    send_bq(1'b0, -1);
    total_cnt++; if (load_err !== 1'b1) $display("FAIL overflow_load_err got %b expected 1", load_err); else pass_cnt++;
    total_cnt++; if (bus.byte_ready !== 1'b0) $display("FAIL overflow_byte_ready got %b expected 0", bus.byte_ready); else pass_cnt++;
    bus.byte_in = 8'h55;
    bus.byte_valid = 1'b1;
    repeat (3) tick();
    bus.byte_valid = 1'b0;
    total_cnt++; if (cpu_rst_n !== 1'b0) $display("FAIL overflow_cpu_rst_n got %b expected 0", cpu_rst_n); else pass_cnt++;
    total_cnt++; if (load_err !== 1'b1 || bus.byte_ready !== 1'b0)
      $display("FAIL overflow_hold got err=%b ready=%b expected err=1 ready=0", load_err, bus.byte_ready); else pass_cnt++;
    pulse_req();
    total_cnt++; if (load_err !== 1'b0) $display("FAIL err_clear got %b expected 0", load_err); else pass_cnt++;
    total_cnt++; if (bus.byte_ready !== 1'b1) $display("FAIL err_to_hdr0 got %b expected 1", bus.byte_ready); else pass_cnt++;
    bq.push_back(8'h04); bq.push_back(8'h00);
    send_bq(1'b0, -1);
    total_cnt++; if (load_err !== 1'b0 || bus.byte_ready !== 1'b1)
      $display("FAIL depth_boundary got err=%b ready=%b expected err=0 ready=1", load_err, bus.byte_ready); else pass_cnt++;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_stall();
    int w0 = wr_cnt;
    pulse_req();
    bq.push_back(8'h00); bq.push_back(8'h03);
    push_word(10'd0, 32'hCAFEBABE);
    push_word(10'd1, 32'h01020304);
    push_word(10'd2, 32'hA5A55A5A);
    send_bq(1'b1, 7);
    repeat (3) tick();
    total_cnt++; if (wr_cnt - w0 !== 3) $display("FAIL stall_write_count got %0d expected 3", wr_cnt - w0); else pass_cnt++;
    total_cnt++; if (cpu_rst_n !== 1'b1 || load_done !== 1'b1)
      $display("FAIL stall_run got rst_n=%b done=%b expected 1 1", cpu_rst_n, load_done); else pass_cnt++;
  endtask

  task automatic test_reset_mid_load();
    int w0 = wr_cnt;
    wr_t first;
    pulse_req();
    bq.push_back(8'h00); bq.push_back(8'h02);
    push_word(10'd0, 32'h11223344);
    bq.push_back(8'h55); bq.push_back(8'h66);
    first = exp_q[0];
    send_bq(1'b0, -1);
    tick();
    rst = 1'b0;
    #1;
    total_cnt++; if (bus.byte_ready !== 1'b0 || bus.imem_we !== 1'b0 || bus.imem_addr !== 10'd0 ||
                     bus.imem_wdata !== 32'd0 || cpu_rst_n !== 1'b0 || load_done !== 1'b0 || load_err !== 1'b0)
      $display("FAIL async_reset got ready=%b we=%b addr=%0h data=%08h rst_n=%b done=%b err=%b expected all 0",
               bus.byte_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, cpu_rst_n, load_done, load_err);
    else pass_cnt++;
    total_cnt++; if (wr_cnt - w0 !== 1) $display("FAIL mid_reset_writes got %0d expected 1 (addr %0h)", wr_cnt - w0, first.a); else pass_cnt++;
    tick();
    rst = 1'b1;
    tick();
    pulse_req();
    bq.push_back(8'h00); bq.push_back(8'h01);
    push_word(10'd0, 32'h0BADF00D);
    send_bq(1'b0, -1);
    repeat (3) tick();
    total_cnt++; if (cpu_rst_n !== 1'b1 || exp_q.size() !== 0)
      $display("FAIL post_reset_load got rst_n=%b pending=%0d expected 1 0", cpu_rst_n, exp_q.size()); else pass_cnt++;
  endtask

  task automatic test_run_reload();
    pulse_req();
    total_cnt++; if (cpu_rst_n !== 1'b0) $display("FAIL run_reload_hold got %b expected 0", cpu_rst_n); else pass_cnt++;
    bq.push_back(8'h00); bq.push_back(8'h01);
    push_word(10'd0, 32'hAABBCCDD);
    send_bq(1'b0, -1);
    repeat (2) tick();
    total_cnt++; if (cpu_rst_n !== 1'b1 || load_done !== 1'b1)
      $display("FAIL run_reload_release got rst_n=%b done=%b expected 1 1", cpu_rst_n, load_done); else pass_cnt++;
    total_cnt++; if (exp_q.size() !== 0) $display("FAIL run_reload_pending got %0d expected 0", exp_q.size()); else pass_cnt++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_two_words();
    test_zero_count();
    test_overflow();
    test_stall();
    test_reset_mid_load();
    test_run_reload();
    repeat (2) tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/imem_prog_loader.md
Name: imem_prog_loader

Overview:
- Byte-stream program loader sitting directly upstream of miniRISC_wrapper.
- Accepts a framed byte stream (16-bit word count header followed by 32-bit instruction words), assembles the words and writes them sequentially into the core's instruction memory write port.
- Holds the core in reset while loading and releases it once the last word is written.
- Lets the bench or board re-program the core without resynthesis.

Parameters:
- ADDR_W, 10, instruction memory address width (word addressed).
- IMEM_DEPTH, 1024, number of writable words; must be ≤ 2**ADDR_W.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- load_req  input  1  single-cycle request to start a new program load.
- byte_in  input  8  stream byte.
- byte_valid  input  1  byte_in is valid this cycle.
- byte_ready  output  1  loader can accept a byte this cycle.
- imem_we  output  1  instruction memory write enable (one-cycle pulse per word).
- imem_addr  output  ADDR_W  word address for the write.
- imem_wdata  output  32  instruction word for the write.
- cpu_rst_n  output  1  active-low reset to miniRISC_wrapper; 0 holds the core in reset.
- load_done  output  1  high while the core runs a successfully loaded program.
- load_err  output  1  high when the header count exceeded IMEM_DEPTH.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst_n=0, load_done=0, load_err=0.
  - Word index, byte counter and count register cleared.
  - Any partially assembled word is discarded.
- Handshake: a byte is accepted when byte_valid && byte_ready at a rising edge. byte_ready is combinational from state: 1 in HDR0, HDR1 and DATA; 0 elsewhere.
- IDLE:
  - cpu_rst_n=0.
  - load_req -> HDR0.
- HDR0: accept byte -> count[15:8]; go to HDR1.
- HDR1: accept byte -> count[7:0], then evaluate the full count:
  - count == 0 -> RUN (core starts, no words written).
  - count > IMEM_DEPTH -> ERR.
  - otherwise -> DATA with index=0 and byte counter=0.
- DATA:
  - Bytes arrive MSB first; shift into a 32-bit assembly register.
  - On the 4th accepted byte -> WRITE.
- WRITE (exactly one cycle):
  - imem_we=1, imem_addr=index, imem_wdata=assembled word; byte_ready=0.
  - imem_we rises the cycle after the 4th byte is accepted.
  - If index == count-1 -> RUN; else index+1 and -> DATA.
- RUN:
  - cpu_rst_n=1 and load_done=1 (both registered, asserted the cycle after entry).
  - load_req -> HDR0: cpu_rst_n=0 and load_done=0 from the next cycle.
- ERR:
  - load_err=1, cpu_rst_n=0, byte_ready=0; remaining stream bytes are not accepted.
  - load_req -> HDR0 and clears load_err.
- Control-path rules:
  - load_req is ignored in HDR0, HDR1, DATA and WRITE (no restart mid-load).
  - byte_valid with byte_ready=0 is not consumed; the source must hold the byte.
  - cpu_rst_n is 0 in every state except RUN.
  - imem_we is never asserted outside WRITE.
  - Index never wraps: the count check guarantees index < IMEM_DEPTH.
- Mid-load reset: outputs return to reset values immediately (asynchronous). Words already written stay in memory; the loader does not clear them.
- Stalls: byte_valid may drop for any number of cycles in any byte-accepting state; no timeout.

Test Plan:
- Reset then load_req; stream 00 02 | 12 34 56 78 | 9A BC DE F0 -> imem_we pulses: addr0=0x12345678, addr1=0x9ABCDEF0. cpu_rst_n=1 and load_done=1 two cycles after the last byte; no further writes.
- Header 00 00 -> no imem_we; cpu_rst_n=1 within 2 cycles of the second header byte.
- Header 04 01 (1025 > 1024) -> load_err=1, cpu_rst_n stays 0, byte_ready=0. A later load_req clears load_err and enters HDR0.
- Load of 3 words with byte_valid toggling every other cycle and a load_req pulse mid-word 1 -> identical writes to the uninterrupted case; load_req has no effect.
- Reset asserted after 6 data bytes of a 2-word load -> all outputs at reset values within the same cycle, only addr0 written. A new load_req completes normally.
- While in RUN, load_req plus a 1-word stream AA BB CC DD -> cpu_rst_n=0 the next cycle, addr0=0xAABBCCDD written, then cpu_rst_n=1 again.
